kmeans_k3n2_data_loader: RTL and testbench

//  Writer side of the k-means point memories. Accepts a valid/ready stream of 2-D points (d0,d1).

---
 rtl/kmeans_pkg.sv | 20 ++
 rtl/kmeans_dp_ram.sv | 31 +++
 rtl/kmeans_k3n2_data_loader.sv | 129 ++++++++++++
 tb/tb_kmeans_k3n2_data_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means types: loader FSM state encoding and width helpers used by the loader and the core.
package kmeans_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } loader_state_e;

   // A counter must reach 2**addr_w, so it needs one bit more than the address.
   function automatic int count_width(input int addr_w);
      return addr_w + 1;
   endfunction

   // Room for 2**addr_w beats of two data_w-bit values each.
   function automatic int checksum_width(input int data_w, input int addr_w);
      return data_w + addr_w + 2;
   endfunction

endpackage

// File: rtl/kmeans_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read-first read port.
module kmeans_dp_ram #(
   parameter int    DW        = 8,
   parameter int    AW        = 8,
   parameter string INIT_FILE = ""
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   // Sampled before the same-edge write lands, so a colliding read sees the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem[ra];
   end

   assign rd = rd_q;

endmodule

// File: rtl/kmeans_k3n2_data_loader.sv
// Point-memory writer for the k-means core: streams qty (d0,d1) points into two RAMs, then pulses kmeans_start.
// Optional feature macro: KMEANS_LOADER_CHECKSUM_EN adds a running checksum output of accepted beats.
module kmeans_k3n2_data_loader
   import kmeans_pkg::*;
#(
   parameter int    data_width               = 8,
   parameter int    input_data_qty_bit_width = 8,
   parameter int    input_data_qty           = 256,
   parameter string mem_d0_init_file         = "./db/d0.txt",
   parameter string mem_d1_init_file         = "./db/d1.txt"
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  load_start,
   input  logic                                                  s_valid,
   output logic                                                  s_ready,
   input  logic [data_width-1:0]                                 s_d0,
   input  logic [data_width-1:0]                                 s_d1,
   input  logic [input_data_qty_bit_width-1:0]                   rd_addr,
   output logic [data_width-1:0]                                 rd_d0,
   output logic [data_width-1:0]                                 rd_d1,
   output logic [count_width(input_data_qty_bit_width)-1:0]      loaded_count,
`ifdef KMEANS_LOADER_CHECKSUM_EN
   output logic [checksum_width(data_width, input_data_qty_bit_width)-1:0] checksum,
`endif
   output logic                                                  busy,
   output logic                                                  done,
   output logic                                                  kmeans_start
);

   localparam int AW = input_data_qty_bit_width;
   localparam int CW = count_width(AW);

   loader_state_e state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, start_d;
   logic          beat, last_beat;

   assign beat      = s_valid & s_ready;
   assign last_beat = (cnt_q == CW'(input_data_qty - 1));

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      cnt_d     = cnt_q;
      start_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_start) begin
               state_d   = ST_LOAD;
               wr_addr_d = '0;
               cnt_d     = '0;
            end
         end
         ST_LOAD: begin
            if (beat) begin
               wr_addr_d = wr_addr_q + AW'(1);
               cnt_d     = cnt_q + CW'(1);
               if (last_beat) begin
                  state_d = ST_DONE;
                  start_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         wr_addr_q <= '0;
         cnt_q     <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         cnt_q     <= cnt_d;
         start_q   <= start_d;
      end
   end

`ifdef KMEANS_LOADER_CHECKSUM_EN
   localparam int SW = checksum_width(data_width, AW);
   logic [SW-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q != ST_LOAD && load_start) sum_d = '0;
      else if (beat)                        sum_d = sum_q + SW'(s_d0) + SW'(s_d1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_q <= '0;
      else      sum_q <= sum_d;
   end

   assign checksum = sum_q;
`endif

   // Ready comes straight off the state flop so the final beat closes the window on the next edge.
   assign s_ready      = (state_q == ST_LOAD);
   assign busy         = (state_q == ST_LOAD);
   assign done         = (state_q == ST_DONE);
   assign kmeans_start = start_q;
   assign loaded_count = cnt_q;

   kmeans_dp_ram #(.DW(data_width), .AW(AW), .INIT_FILE(mem_d0_init_file)) u_ram_d0 (
      .clk   (clk),
      .rst_n (rst),
      .we    (beat),
      .wa    (wr_addr_q),
      .wd    (s_d0),
      .ra    (rd_addr),
      .rd    (rd_d0)
   );

   kmeans_dp_ram #(.DW(data_width), .AW(AW), .INIT_FILE(mem_d1_init_file)) u_ram_d1 (
      .clk   (clk),
      .rst_n (rst),
      .we    (beat),
      .wa    (wr_addr_q),
      .wd    (s_d1),
      .ra    (rd_addr),
      .rd    (rd_d1)
   );

endmodule

// File: tb/tb_kmeans_k3n2_data_loader.sv
// Directed bench for the k-means point loader with qty=4 and a 2-bit address (qty at the 2**AW boundary).
module tb_kmeans_k3n2_data_loader;

   localparam int DW  = 8;
   localparam int AW  = 2;
   localparam int QTY = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_start = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_d0 = '0;
   logic [DW-1:0] s_d1 = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          s_ready, busy, done, kmeans_start;
   logic [DW-1:0] rd_d0, rd_d1;
   logic [AW:0]   loaded_count;
`ifdef KMEANS_LOADER_CHECKSUM_EN
   logic [DW+AW+1:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   kmeans_k3n2_data_loader #(
      .data_width               (DW),
      .input_data_qty_bit_width (AW),
      .input_data_qty           (QTY),
      .mem_d0_init_file         (""),
      .mem_d1_init_file         ("")
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_d0         (s_d0),
      .s_d1         (s_d1),
      .rd_addr      (rd_addr),
      .rd_d0        (rd_d0),
      .rd_d1        (rd_d1),
      .loaded_count (loaded_count),
`ifdef KMEANS_LOADER_CHECKSUM_EN
      .checksum     (checksum),
`endif
      .busy         (busy),
      .done         (done),
      .kmeans_start (kmeans_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ls, sv;
      logic [DW-1:0] d0, d1;
      logic [AW-1:0] ra;
      logic          rchk;
      logic          rdy, dn, st;
      logic [AW:0]   cnt;
      logic [DW-1:0] r0, r1;
   } vec_t;

   vec_t tbl [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ls, input logic sv, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      load_start = ls;
      s_valid    = sv;
      s_d0       = d0;
      s_d1       = d1;
   endtask

   task automatic chk_state(input string nm, input logic rdy, input logic dn, input logic st, input int cnt);
      chk({nm, " s_ready"},      32'(s_ready),      32'(rdy));
      chk({nm, " busy"},         32'(busy),         32'(rdy));
      chk({nm, " done"},         32'(done),         32'(dn));
      chk({nm, " kmeans_start"}, 32'(kmeans_start), 32'(st));
      chk({nm, " loaded_count"}, 32'(loaded_count), 32'(cnt));
   endtask

   initial begin
      // Test 2 stimulus: load (1,2)..(7,8), then read back.
      tbl[0] = '{1'b1, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0};
      tbl[1] = '{1'b0, 1'b1, 8'd1, 8'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0, 8'd0};
      tbl[2] = '{1'b0, 1'b1, 8'd3, 8'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 8'd0};
      tbl[3] = '{1'b0, 1'b1, 8'd5, 8'd6, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 8'd0};
      tbl[4] = '{1'b0, 1'b1, 8'd7, 8'd8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'd0, 8'd0};
      tbl[5] = '{1'b0, 1'b1, 8'd9, 8'd9, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 8'd0, 8'd0};
      tbl[6] = '{1'b0, 1'b0, 8'd0, 8'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd5, 8'd6};
      tbl[7] = '{1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd1, 8'd2};
      tbl[8] = '{1'b0, 1'b0, 8'd0, 8'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 8'd7, 8'd8};

      // Reset state
      tick();
      tick();
      chk_state("reset", 1'b0, 1'b0, 1'b0, 0);
      chk("reset rd_d0", 32'(rd_d0), 32'd0);
      rst = 1'b1;
      tick();

      // Test 1: async reset mid-load takes effect without a clock edge
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      tick();
      drive(1'b0, 1'b1, 8'd9, 8'd9);
      tick();
      chk("t1 pre-reset count", 32'(loaded_count), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk_state("t1 async reset", 1'b0, 1'b0, 1'b0, 0);
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      #1 rst = 1'b1;
      tick();
      chk_state("t1 after release", 1'b0, 1'b0, 1'b0, 0);

      // Test 2: back-to-back load, table-driven
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].ls, tbl[i].sv, tbl[i].d0, tbl[i].d1);
         rd_addr = tbl[i].ra;
         tick();
         chk_state($sformatf("t2 vec%0d", i), tbl[i].rdy, tbl[i].dn, tbl[i].st, int'(tbl[i].cnt));
         if (tbl[i].rchk) begin
            chk($sformatf("t2 vec%0d rd_d0", i), 32'(rd_d0), 32'(tbl[i].r0));
            chk($sformatf("t2 vec%0d rd_d1", i), 32'(rd_d1), 32'(tbl[i].r1));
         end
      end

      // Test 3: s_valid toggling; also a read colliding with a write returns old data
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      rd_addr = 2'd0;
      tick();
      chk_state("t3 reload", 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, (i % 2 == 0), 8'(10 + i / 2), 8'(20 + i / 2));
         tick();
         chk_state($sformatf("t3 cyc%0d", i), (i < 6), (i >= 6), (i == 6), i / 2 + 1);
         if (i == 0) chk("t3 read-first rd_d0", 32'(rd_d0), 32'd1);
         if (i == 1) chk("t3 new rd_d0", 32'(rd_d0), 32'd10);
         if (i == 1) chk("t3 new rd_d1", 32'(rd_d1), 32'd20);
      end

      // Test 4: load_start in DONE restarts, load_start in LOAD ignored
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      tick();
      chk_state("t4 restart", 1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         drive((k == 1), 1'b1, 8'(100 + k), 8'(200 + k));
         tick();
         chk_state($sformatf("t4 beat%0d", k), (k < 3), (k == 3), (k == 3), k + 1);
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      chk_state("t4 done hold", 1'b0, 1'b1, 1'b0, 4);

      // Test 5: reset after 2 of 4 beats keeps partial and older RAM contents
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      tick();
      drive(1'b0, 1'b1, 8'd1, 8'd1);
      tick();
      drive(1'b0, 1'b1, 8'd2, 8'd2);
      tick();
      chk("t5 count before reset", 32'(loaded_count), 32'd2);
      #2 rst = 1'b0;
      #1;
      chk_state("t5 reset", 1'b0, 1'b0, 1'b0, 0);
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      #1 rst = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         tick();
         chk($sformatf("t5 ram0[%0d]", a), 32'(rd_d0), (a < 2) ? 32'(a + 1) : 32'(100 + a));
         chk($sformatf("t5 ram1[%0d]", a), 32'(rd_d1), (a < 2) ? 32'(a + 1) : 32'(200 + a));
      end
      chk_state("t5 idle", 1'b0, 1'b0, 1'b0, 0);

`ifdef KMEANS_LOADER_CHECKSUM_EN
      // Test 6: checksum of four (255,255) beats
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      tick();
      chk("t6 checksum cleared", 32'(checksum), 32'd0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, 8'd255, 8'd255);
         tick();
      end
      drive(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      chk("t6 checksum", 32'(checksum), 32'd2040);
      chk("t6 done", 32'(done), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
